// File: rtl/buyruk_onbellegi.sv
// Direct-mapped instruction-cache storage array for the fetch stage: one-cycle
// lookups, 128-bit block fills and a one-line-per-cycle valid sweep.
module buyruk_onbellegi #(
    parameter int SATIR_SAYISI = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         istek_g,
    input  logic [31:0]  adres_g,
    input  logic         obegi_yaz_g,
    input  logic [31:0]  yaz_adres_g,
    input  logic [127:0] obek_g,
    input  logic         gecersiz_kil_g,
    output logic [31:0]  veri_c,
    output logic         veri_bulundu_c,
    output logic         bitti_c,
    output logic         mesgul_c
);

    localparam int IB = $clog2(SATIR_SAYISI);
    localparam int TW = 28 - IB;
    localparam logic [IB-1:0] SON_SATIR = IB'(SATIR_SAYISI - 1);

    typedef enum logic {
        HAZIR   = 1'b0,
        TEMIZLE = 1'b1
    } durum_t;

    durum_t        durum, durum_n;
    logic [IB-1:0] sayac, sayac_n;
    logic          temizle;

    logic [SATIR_SAYISI-1:0] gecerli;
    logic [TW-1:0]           etiket_dizisi [SATIR_SAYISI];
    logic [127:0]            veri_dizisi   [SATIR_SAYISI];

    logic [IB-1:0] oku_satir, yaz_satir;
    logic [TW-1:0] oku_etiket, yaz_etiket;
    logic [1:0]    kelime;
    logic          kabul, yazma, isabet;
    logic [127:0]  okunan_blok;
    logic [31:0]   okunan_kelime;

    assign oku_satir  = adres_g[IB+3:4];
    assign oku_etiket = adres_g[31:IB+4];
    assign kelime     = adres_g[3:2];
    assign yaz_satir  = yaz_adres_g[IB+3:4];
    assign yaz_etiket = yaz_adres_g[31:IB+4];

    assign kabul    = (durum == HAZIR) && istek_g;
    assign yazma    = !rst && (durum == HAZIR) && obegi_yaz_g && !gecersiz_kil_g;
    assign mesgul_c = (durum == TEMIZLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= TEMIZLE;
            sayac <= '0;
        end else begin
            durum <= durum_n;
            sayac <= sayac_n;
        end
    end

    always_comb begin
        durum_n = durum;
        sayac_n = sayac;
        temizle = 1'b0;
        unique case (durum)
            TEMIZLE: begin
                temizle = 1'b1;
                if (gecersiz_kil_g) begin
                    sayac_n = '0;
                end else begin
                    sayac_n = sayac + IB'(1);
                    if (sayac == SON_SATIR) durum_n = HAZIR;
                end
            end
            HAZIR: begin
                if (gecersiz_kil_g) begin
                    durum_n = TEMIZLE;
                    sayac_n = '0;
                end
            end
            default: begin
                durum_n = TEMIZLE;
                sayac_n = '0;
            end
        endcase
    end

    // NOTE: the storage arrays have no reset; the valid sweep is what makes stale contents harmless.
    always_ff @(posedge clk) begin
        if (yazma) begin
            veri_dizisi[yaz_satir]   <= obek_g;
            etiket_dizisi[yaz_satir] <= yaz_etiket;
        end
    end

    always_ff @(posedge clk) begin
        if (temizle) begin
            gecerli[sayac] <= 1'b0;
        end else if (yazma) begin
            gecerli[yaz_satir] <= 1'b1;
        end
    end

    // A fill landing on the looked-up line this edge is forwarded straight to the result.
    always_comb begin
        if (yazma && (yaz_satir == oku_satir)) begin
            isabet      = (yaz_etiket == oku_etiket);
            okunan_blok = obek_g;
        end else begin
            isabet      = gecerli[oku_satir] && (etiket_dizisi[oku_satir] == oku_etiket);
            okunan_blok = veri_dizisi[oku_satir];
        end
        okunan_kelime = okunan_blok[{kelime, 5'b00000} +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitti_c        <= 1'b0;
            veri_bulundu_c <= 1'b0;
            veri_c         <= '0;
        end else begin
            bitti_c        <= kabul;
            veri_bulundu_c <= kabul && isabet;
            if (kabul) veri_c <= okunan_kelime;
        end
    end

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Self-checking bench for buyruk_onbellegi: directed scenarios followed by random
// traffic, all compared against a line-level behavioural model of the cache.
module tb_buyruk_onbellegi;

    localparam int N  = 64;
    localparam int IB = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         istek_g;
    logic [31:0]  adres_g;
    logic         obegi_yaz_g;
    logic [31:0]  yaz_adres_g;
    logic [127:0] obek_g;
    logic         gecersiz_kil_g;
    logic [31:0]  veri_c;
    logic         veri_bulundu_c;
    logic         bitti_c;
    logic         mesgul_c;

    buyruk_onbellegi #(.SATIR_SAYISI(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .istek_g        (istek_g),
        .adres_g        (adres_g),
        .obegi_yaz_g    (obegi_yaz_g),
        .yaz_adres_g    (yaz_adres_g),
        .obek_g         (obek_g),
        .gecersiz_kil_g (gecersiz_kil_g),
        .veri_c         (veri_c),
        .veri_bulundu_c (veri_bulundu_c),
        .bitti_c        (bitti_c),
        .mesgul_c       (mesgul_c)
    );

    always #5 clk = ~clk;

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    // Model: what each line holds, plus how many more edges the current sweep lasts.
    bit           m_gecerli [N];
    int unsigned  m_etiket  [N];
    logic [127:0] m_veri    [N];
    bit           m_bilinir [N];
    int           m_kalan;
    logic         exp_bitti, exp_bulundu;
    logic [31:0]  exp_veri;
    bit           exp_veri_bilinir;

    task automatic check(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        assert (gozlenen === beklenen)
        else begin
            hata_sayisi++;
            $error("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic hepsini_sil();
        for (int i = 0; i < N; i++) m_gecerli[i] = 1'b0;
    endtask

    task automatic step(input logic r, input logic ist, input logic [31:0] a,
                        input logic fy, input logic [31:0] fa, input logic [127:0] blk,
                        input logic gk);
        int          s;
        bit          hazir;
        logic [127:0] satir;
        rst = r; istek_g = ist; adres_g = a; obegi_yaz_g = fy;
        yaz_adres_g = fa; obek_g = blk; gecersiz_kil_g = gk;
        @(posedge clk);
        if (r) begin
            m_kalan = N;
            hepsini_sil();
            exp_bitti = 1'b0; exp_bulundu = 1'b0; exp_veri = '0; exp_veri_bilinir = 1'b1;
        end else begin
            hazir = (m_kalan == 0);
            if (hazir && fy && !gk) begin
                s = int'((fa >> 4) % N);
                m_gecerli[s] = 1'b1;
                m_etiket[s]  = fa >> (4 + IB);
                m_veri[s]    = blk;
                m_bilinir[s] = 1'b1;
            end
            exp_bitti   = hazir && ist;
            exp_bulundu = 1'b0;
            if (exp_bitti) begin
                s = int'((a >> 4) % N);
                exp_bulundu      = m_gecerli[s] && (m_etiket[s] == (a >> (4 + IB)));
                exp_veri_bilinir = m_bilinir[s];
                satir            = m_veri[s];
                exp_veri         = satir[int'((a >> 2) % 4) * 32 +: 32];
            end
            if (gk) begin
                m_kalan = N;
                hepsini_sil();
            end else if (!hazir) begin
                m_kalan--;
            end
        end
        #1;
        check("bitti_c", 32'(bitti_c), 32'(exp_bitti));
        check("veri_bulundu_c", 32'(veri_bulundu_c), 32'(exp_bulundu));
        check("mesgul_c", 32'(mesgul_c), 32'(m_kalan > 0));
        if (exp_veri_bilinir) check("veri_c", veri_c, exp_veri);
    endtask

    task automatic ara(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doldur(input logic [31:0] fa, input logic [127:0] blk);
        step(1'b0, 1'b0, '0, 1'b1, fa, blk, 1'b0);
    endtask

    localparam logic [127:0] OBEK_A = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    localparam logic [127:0] OBEK_B = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] OBEK_C = {32'h9999_0003, 32'h9999_0002, 32'h1234_5678, 32'h9999_0000};

    initial begin
        int mesgul_say;
        logic [31:0] ra, fa;

        for (int i = 0; i < N; i++) begin
            m_gecerli[i] = 1'b0; m_etiket[i] = 0; m_veri[i] = '0; m_bilinir[i] = 1'b0;
        end
        m_kalan = N; exp_veri_bilinir = 1'b0;

        // Reset sweep with a lookup held the whole time.
        repeat (3) step(1'b1, 1'b1, 32'h0000_1008, 1'b0, '0, '0, 1'b0);
        mesgul_say = mesgul_c ? 1 : 0;
        for (int i = 0; i < N + 1; i++) begin
            step(1'b0, 1'b1, 32'h0000_1008, 1'b0, '0, '0, 1'b0);
            if (mesgul_c) mesgul_say++;
        end
        check("reset_sweep_len", 32'(mesgul_say), 32'(N));
        check("reset_first_done", 32'(bitti_c), 32'd1);
        check("reset_first_miss", 32'(veri_bulundu_c), 32'd0);

        // Miss, fill, hit.
        ara(32'h0000_1008);
        check("miss_before_fill", 32'(veri_bulundu_c), 32'd0);
        doldur(32'h0000_1000, OBEK_A);
        ara(32'h0000_1008);
        check("hit_word2", veri_c, 32'hCCCC_CCCC);
        ara(32'h0000_100C);
        check("hit_word3", veri_c, 32'hDDDD_DDDD);

        // Conflict eviction at index 0.
        doldur(32'h0000_2000, OBEK_B);
        ara(32'h0000_1000);
        check("evicted_miss", 32'(veri_bulundu_c), 32'd0);
        ara(32'h0000_2000);
        check("new_line_hit", 32'(veri_bulundu_c), 32'd1);

        // Fill and lookup of the same line on one edge.
        step(1'b0, 1'b1, 32'h0000_3014, 1'b1, 32'h0000_3010, OBEK_C, 1'b0);
        check("bypass_hit", 32'(veri_bulundu_c), 32'd1);
        check("bypass_data", veri_c, 32'h1234_5678);

        // Invalidate: the lookup on the pulse edge still sees the old line.
        doldur(32'h0000_1000, OBEK_A);
        doldur(32'h0000_2010, OBEK_B);
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0, '0, '0, 1'b1);
        check("inval_edge_hit", 32'(veri_bulundu_c), 32'd1);
        check("inval_edge_data", veri_c, 32'hAAAA_AAAA);
        mesgul_say = mesgul_c ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, 32'h0000_1000, 1'b0, '0, '0, 1'b0);
            if (mesgul_c) mesgul_say++;
        end
        check("inval_sweep_len", 32'(mesgul_say), 32'(N));
        ara(32'h0000_1000);
        check("inval_miss_1000", 32'(veri_bulundu_c), 32'd0);
        ara(32'h0000_2010);
        check("inval_miss_2010", 32'(veri_bulundu_c), 32'd0);

        // Back-to-back lookups across one block.
        doldur(32'h0000_1000, OBEK_A);
        for (int w = 0; w < 4; w++) ara(32'h0000_1000 + 32'(4 * w));
        check("b2b_last_word", veri_c, 32'hDDDD_DDDD);

        // Random traffic over a few tags and lines so hits, conflicts and bypasses recur.
        for (int i = 0; i < 800; i++) begin
            ra = 32'($urandom_range(0, 3) << (4 + IB)) | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
            fa = 32'($urandom_range(0, 3) << (4 + IB)) | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, ra,
                 $urandom_range(0, 2) == 0, fa, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 119) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
